uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- UART transmitter: serialises bytes onto the line that the team's UART_RX samples; 8N1 framing, LSB first, idle high.
- Bytes enter through a valid/ready handshake into a shallow FIFO, so producers can burst several bytes without waiting on the serial line.
- Intended use: on-chip byte source driving the UART line, and loopback partner for UART_RX in benches.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (217 at 25 MHz gives ~115200 baud); legal values >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_data  input  8  byte to send.
- tx_ready  output  1  FIFO can accept; high when FIFO not full.
- tx  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame is on the line.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes waiting (not counting the frame in flight).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: tx=1, tx_ready=1, tx_busy=0, fifo_count=0; FSM in IDLE; FIFO flushed.
- Push rule: a byte is written on a clk edge where tx_valid && tx_ready.
  - tx_valid while !tx_ready is ignored; the byte is not stored and no error is flagged.
  - The producer holds tx_data stable until accepted.
- tx_ready is derived from the registered count: a pop in the same cycle does not admit a push into a full FIFO.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty, pop the head into the shift register, clear bit_cnt and clk_cnt, go to START.
  - tx goes low at the same edge as the pop.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit, then shift right.
  - Exactly 8 bits, then go to STOP.
- STOP: tx=1 for exactly CLKS_PER_BIT cycles. On its last cycle:
  - FIFO non-empty: pop and go directly to START, with no extra idle cycle; the stop bit is exactly CLKS_PER_BIT.
  - Otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the falling edge of tx to the end of the stop bit.
- Latency: a byte pushed into an empty FIFO while in IDLE at edge N is popped at edge N+1, and tx falls at N+1.
- tx_busy = (state != IDLE); asserted from the pop edge through the last stop-bit cycle.
- fifo_count:
  - +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - Never exceeds FIFO_DEPTH; never underflows, because pops only occur when non-empty.
- Pointers: log2(FIFO_DEPTH) bits each, wrap naturally.
- Counter width: clk_cnt is $clog2(CLKS_PER_BIT) bits, compared against CLKS_PER_BIT-1.
- Reset mid-frame: tx returns high immediately (asynchronously), the frame is truncated, and queued bytes are discarded.
- No parity, no break generation, no flow-control pins.

Decomposition:
- Package uart_pkg:
  - FSM state enum {IDLE, START, DATA, STOP}.
  - DATA_BITS=8 and STOP_BITS=1 constants.
  - Idle-line level constant (1'b1).
  - Shared with UART_RX.
- Sub-module sync_fifo:
  - Parameters: width 8, depth FIFO_DEPTH.
  - Ports: clk, rst_n, wr_en, wr_data, rd_en, rd_data (first-word fall-through), full, empty, count.
- uart_tx_fifo contains the FSM, bit/clock counters and shift register, and instantiates sync_fifo.

Test Plan:
- Single byte 0xA5, CLKS_PER_BIT=217, 40 ns clock:
  - tx low 217 cycles, then bits 1,0,1,0,0,1,0,1, then high 217 cycles; frame is 2170 cycles.
  - tx_busy spans exactly the frame.
  - Loopback into UART_RX yields rx_data=8'hA5.
- Back-to-back 0x00 then 0xFF, CLKS_PER_BIT=4:
  - 0x00 frame: start bit plus eight 0 data bits, tx low 36 cycles; then exactly 4 stop cycles high.
  - Next start bit follows with no gap.
  - 0xFF frame: tx low 4 cycles (start), then high 32 cycles of data plus the stop bit.
- Burst of 6 bytes 0x01..0x06, tx_valid held high, depth 4, CLKS_PER_BIT=4:
  - First 5 bytes are accepted on consecutive edges, the first popped immediately.
  - tx_ready drops with fifo_count=4.
  - The 6th is accepted one edge after the first pop following frame 1.
  - Line order is 01..06.
- Push while full with tx_valid pulsed for one cycle: byte dropped, fifo_count stays 4, the remaining four frames are unaffected.
- Assert rst_n low midway through the DATA state of a frame with 2 bytes queued:
  - tx=1 immediately; fifo_count=0, tx_busy=0.
  - After release, no further frame starts until a new push.
- Idle check: no pushes for 1000 cycles after reset -> tx constantly 1, tx_ready=1, tx_busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state FSM encoding and frame constants,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-producer interface of the UART transmitter: valid/ready push side
// plus the serial line and status outputs.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx;
    logic                 tx_busy;
    logic [CW-1:0]        fifo_count;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx, tx_busy, fifo_count
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx, tx_busy, fifo_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Shallow synchronous FIFO with first-word fall-through read data; full,
// empty and count all come straight from the registered occupancy.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small FIFO; consecutive queued bytes go
// out back to back with no idle gap between the stop bit and the next start.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_fifo_if.slave  bus
);
    localparam int                CW        = $clog2(FIFO_DEPTH + 1);
    localparam int                CCW       = $clog2(CLKS_PER_BIT);
    localparam int                BCW       = $clog2(DATA_BITS);
    localparam logic [CCW-1:0]    LAST_TICK = CCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]    LAST_BIT  = BCW'(DATA_BITS - 1);

    uart_state_t          r_state, w_state_next;
    logic [CCW-1:0]       r_clk_cnt, w_clk_cnt_next;
    logic [BCW-1:0]       r_bit_cnt, w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_tx, w_tx_next;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_tick;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;

    assign w_push         = bus.tx_valid && !w_full;
    assign w_tick         = (r_clk_cnt == LAST_TICK);
    assign bus.tx_ready   = !w_full;
    assign bus.tx         = r_tx;
    assign bus.tx_busy    = (r_state != IDLE);
    assign bus.fifo_count = w_count;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_data (bus.tx_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // A new frame starts either from idle or on the last stop-bit cycle.
    assign w_pop = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_tick));

    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_tx_next      = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_next = IDLE_LEVEL;
            end
            START: begin
                if (w_tick) begin
                    w_clk_cnt_next = '0;
                    w_tx_next      = r_shift[0];
                    w_state_next   = DATA;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_clk_cnt_next = '0;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_tx_next    = IDLE_LEVEL;
                        w_state_next = STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                        w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_next      = r_shift[1];
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_clk_cnt_next = '0;
                    w_tx_next      = IDLE_LEVEL;
                    w_state_next   = IDLE;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_next    = IDLE_LEVEL;
                w_state_next = IDLE;
            end
        endcase
        if (w_pop) begin
            w_shift_next   = w_fifo_data;
            w_clk_cnt_next = '0;
            w_bit_cnt_next = '0;
            w_tx_next      = 1'b0;
            w_state_next   = START;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= IDLE_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

endmodule
